// File: rtl/goertzel_pkg.sv
// goertzel_pkg: shared Q-format constant, FSM states and sample conversion
package goertzel_pkg;
  localparam int FRAC_BITS = 14;
  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;
  // Offset-binary w-bit sample to signed 16-bit: subtracting the mid-code flips the MSB and sign-extends
  function automatic logic signed [15:0] to_signed_sample(input logic [15:0] d, input int w);
    return d - (16'd1 << (w - 1));
  endfunction
endpackage

// File: rtl/dsp_16x16_fix14_16_signed_mul.sv
// dsp_16x16_fix14_16_signed_mul: registered signed 16x16 multiply returning the Q2.14-aligned 16-bit slice
module dsp_16x16_fix14_16_signed_mul
  import goertzel_pkg::*;
(
  input  logic        sys_clk,
  input  logic        dsp_CE,
  input  logic [15:0] dsp_A,
  input  logic [15:0] dsp_B,
  output logic [15:0] fix_14_16_Out
);
  logic signed [31:0] p;
  assign p = $signed(dsp_A) * $signed(dsp_B);
  // One-cycle product register, floor shift by FRAC_BITS and wrap to 16 bits
  always_ff @(posedge sys_clk)
    if (dsp_CE) fix_14_16_Out <= 16'(p >>> FRAC_BITS);
endmodule

// File: rtl/goertzel_recursion_core.sv
// goertzel_recursion_core: single-bin Goertzel recursion streaming samples from an external RAM
module goertzel_recursion_core
  import goertzel_pkg::*;
#(
  parameter int NUM_SAMPLES = 512,
  parameter int NS_BITS     = 9,
  parameter int B_W         = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               enable,
  input  logic               start,
  input  logic [15:0]        coeff,
  input  logic [B_W-1:0]     data_n,
  output logic [15:0]        T1,
  output logic [15:0]        T2,
  output logic [NS_BITS-1:0] read_address,
  output logic               ready,
  output logic               done
);
  state_t              state;
  logic [15:0]         s1, s2, p, x;
  logic [NS_BITS-1:0]  idx;
  assign x = to_signed_sample(16'(data_n), B_W);
  assign T1 = s1;
  assign T2 = s2;
  assign read_address = idx;
  // Reset forces a zero operand through the multiplier so its register clears without a reset port
  dsp_16x16_fix14_16_signed_mul u_mul (
    .sys_clk       (sys_clk),
    .dsp_CE        (enable | ~sys_rst_n),
    .dsp_A         (sys_rst_n ? s1 : 16'd0),
    .dsp_B         (coeff),
    .fix_14_16_Out (p)
  );
  // Two enabled cycles per sample: MUL latches coeff*s1 and the RAM word, ACC folds them into the state
  always_ff @(posedge sys_clk)
    if (!sys_rst_n) begin
      state <= IDLE;
      s1    <= '0;
      s2    <= '0;
      idx   <= '0;
      ready <= 1'b1;
      done  <= 1'b0;
    end else if (enable)
      case (state)
        IDLE, DONE:
          if (start) begin
            state <= MUL;
            s1    <= '0;
            s2    <= '0;
            idx   <= '0;
            ready <= 1'b0;
            done  <= 1'b0;
          end
        MUL: state <= ACC;
        ACC: begin
          s2 <= s1;
          s1 <= x + p - s2;
          if (idx == NS_BITS'(NUM_SAMPLES - 1)) begin
            state <= DONE;
            ready <= 1'b1;
            done  <= 1'b1;
          end else begin
            idx   <= idx + 1'b1;
            state <= MUL;
          end
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_goertzel_recursion_core.sv
// tb_goertzel_recursion_core: directed and randomized checks of the Goertzel core against a plain arithmetic model
module tb_goertzel_recursion_core;
  localparam int NS = 512;
  logic        sys_clk = 0, sys_rst_n = 0, enable = 0, start = 0;
  logic [15:0] coeff = 0;
  logic [7:0]  data_n = 8'h80;
  logic [15:0] T1, T2;
  logic [8:0]  read_address;
  logic        ready, done;
  logic        mce = 0;
  logic [15:0] ma = 0, mb = 0, mo;
  logic [7:0]  mem [NS];
  int          errors = 0, checks = 0;
  int          cyc, seen;
  logic        acc_done;
  logic [31:0] exp_t;

  goertzel_recursion_core #(.NUM_SAMPLES(NS), .NS_BITS(9), .B_W(8)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .start(start),
    .coeff(coeff), .data_n(data_n), .T1(T1), .T2(T2),
    .read_address(read_address), .ready(ready), .done(done)
  );

  dsp_16x16_fix14_16_signed_mul mul (
    .sys_clk(sys_clk), .dsp_CE(mce), .dsp_A(ma), .dsp_B(mb), .fix_14_16_Out(mo)
  );

  always #5 sys_clk = ~sys_clk;

  // External synchronous-read sample RAM, one enabled cycle of latency
  always @(posedge sys_clk) if (enable) data_n <= mem[read_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // mode 0: all mid-code, 1: unit impulse at sample 0, 2: random
  task automatic fill(input int mode);
    for (int k = 0; k < NS; k++)
      mem[k] = (mode == 2) ? 8'($urandom) : ((mode == 1 && k == 0) ? 8'h81 : 8'h80);
  endtask

  // Goertzel recursion computed directly from the equation with wide integers
  function automatic logic [31:0] model(input logic signed [15:0] c);
    logic signed [15:0] a, b, n;
    longint pr;
    a = 0;
    b = 0;
    for (int k = 0; k < NS; k++) begin
      pr = (longint'(c) * longint'(a)) >>> 14;
      n  = 16'(longint'(mem[k]) - 128 + pr - longint'(b));
      b  = a;
      a  = n;
    end
    return {a, b};
  endfunction

  task automatic reset_check(input string tag);
    start     = 0;
    sys_rst_n = 0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_T1T2"}, {T1, T2}, 32'd0);
    chk({tag, "_addr"}, 32'(read_address), 32'd0);
    sys_rst_n = 1;
  endtask

  // Start a block and count clock edges until done; tog alternates enable starting with a disabled edge
  task automatic run(input logic [15:0] c, input bit tog, input bit busy_start,
                     output int n, output logic dacc);
    coeff  = c;
    enable = !tog;
    start  = 1;
    n      = 0;
    dacc   = 1'bx;
    while (n < 5000) begin
      @(posedge sys_clk);
      #1;
      n++;
      if (n == (tog ? 2 : 1)) dacc = done;
      start = (n < (tog ? 2 : 1)) || (busy_start && n >= 100 && n < 110);
      if (tog) enable = ~enable;
      if (done && !(tog && n == 1)) break;
    end
    start  = 0;
    enable = 1;
  endtask

  initial begin
    ma = 16'h4000; mb = 16'h2000; mce = 1;
    @(posedge sys_clk); #1;
    chk("mul_half", 32'(mo), 32'h2000);
    ma = 16'hC000; mb = 16'h4000;
    #1;
    chk("mul_latency", 32'(mo), 32'h2000);
    @(posedge sys_clk); #1;
    chk("mul_neg", 32'(mo), 32'hC000);
    ma = 16'hFFFF; mb = 16'h0001;
    @(posedge sys_clk); #1;
    chk("mul_floor", 32'(mo), 32'hFFFF);
    mce = 0; ma = 16'h4000; mb = 16'h4000;
    @(posedge sys_clk); #1;
    chk("mul_ce_hold", 32'(mo), 32'hFFFF);

    enable = 1;
    reset_check("rst");

    fill(0);
    run(16'h4000, 0, 0, cyc, acc_done);
    chk("zero_cycles", 32'(cyc), 32'd1025);
    chk("zero_T1T2", {T1, T2}, 32'h0000_0000);
    chk("zero_addr_hold", 32'(read_address), 32'd511);
    chk("zero_ready", 32'(ready), 32'd1);

    fill(1);
    run(16'h0000, 0, 0, cyc, acc_done);
    chk("c0_T1T2", {T1, T2}, 32'h0000_FFFF);
    chk("c0_model", {T1, T2}, model(16'h0000));

    run(16'h4000, 0, 0, cyc, acc_done);
    chk("c1_done_drop", 32'(acc_done), 32'd0);
    chk("c1_cycles", 32'(cyc), 32'd1025);
    chk("c1_T1T2", {T1, T2}, 32'h0001_0001);

    run(16'h4000, 1, 0, cyc, acc_done);
    chk("tog_cycles", 32'(cyc), 32'd2050);
    chk("tog_T1T2", {T1, T2}, 32'h0001_0001);

    run(16'h4000, 0, 1, cyc, acc_done);
    chk("busy_done_drop", 32'(acc_done), 32'd0);
    chk("busy_cycles", 32'(cyc), 32'd1025);
    chk("busy_T1T2", {T1, T2}, 32'h0001_0001);

    for (int r = 0; r < 4; r++) begin
      fill(2);
      coeff = 16'($urandom);
      exp_t = model(coeff);
      run(coeff, r[0], 0, cyc, acc_done);
      chk("rand_cycles", 32'(cyc), r[0] ? 32'd2050 : 32'd1025);
      chk("rand_T1T2", {T1, T2}, exp_t);
    end

    coeff = 16'h4000;
    start = 1;
    @(posedge sys_clk); #1;
    start = 0;
    repeat (300) @(posedge sys_clk);
    #1;
    chk("midrun_busy", 32'(ready), 32'd0);
    reset_check("midrst");
    seen = 0;
    repeat (1200) begin
      @(posedge sys_clk); #1;
      if (done) seen++;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    chk("midrst_idle_ready", 32'(ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
